// File: rtl/nrzi_pkg.sv
// Shared types and default sizing for the NRZI receiver.
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  localparam int WIDTH_DEF    = 8;
  localparam int MAX_ONES_DEF = 6;

endpackage

// File: rtl/nrzi_bit_decode.sv
// NRZI line decoder: a line toggle means 1, a held level means 0.
// Only strobed samples move the reference level.
module nrzi_bit_decode (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_en,
  output logic bit_val,
  output logic bit_stb
);

  logic ref_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_level <= 1'b0;
    end else if (din_en) begin
      ref_level <= din;
    end
  end

  assign bit_val = din ^ ref_level;
  assign bit_stb = din_en;

endmodule

// File: rtl/nrzi_rx.sv
// NRZI frame receiver: start bit, WIDTH data bits LSB first, stop bit 0,
// one-word holding register with valid/ready. Define BIT_UNSTUFF_EN to strip stuffed zeros.
module nrzi_rx
  import nrzi_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_ONES = MAX_ONES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             bit_val;
  logic             bit_stb;
  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;

`ifdef BIT_UNSTUFF_EN
  localparam int               ONES_W     = $clog2(MAX_ONES + 1);
  localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(MAX_ONES);
  logic [ONES_W-1:0] ones_cnt;
`endif

  nrzi_bit_decode u_decode (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_en  (din_en),
    .bit_val (bit_val),
    .bit_stb (bit_stb)
  );

  // The assembly register is pure data: every bit is rewritten each frame.
  always_ff @(posedge clk) begin
    if (bit_stb && state == DATA) begin
`ifdef BIT_UNSTUFF_EN
      if (ones_cnt != ONES_LIMIT) begin
        shreg[bit_cnt] <= bit_val;
      end
`else
      shreg[bit_cnt] <= bit_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef BIT_UNSTUFF_EN
      ones_cnt   <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (bit_stb) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
`ifdef BIT_UNSTUFF_EN
            ones_cnt <= '0;
`endif
            if (bit_val) begin
              state <= DATA;
            end
          end
          DATA: begin
`ifdef BIT_UNSTUFF_EN
            // A run of MAX_ONES ones is followed by a stuffed zero that carries no data.
            if (ones_cnt == ONES_LIMIT) begin
              ones_cnt <= '0;
              if (bit_val) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else begin
              ones_cnt <= bit_val ? ones_cnt + 1'b1 : '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end
`else
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
`endif
          end
          STOP: begin
            state <= IDLE;
            if (bit_val) begin
              frame_err <= 1'b1;
            end else if (!dout_valid || dout_ready) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrzi_rx.sv
// Self-checking bench for nrzi_rx: vector table, hand-written corner sequences,
// and an event scoreboard fed by the stimulus and drained by an output monitor.
module tb_nrzi_rx;
  import nrzi_pkg::*;

  localparam int WIDTH    = 8;
  localparam int MAX_ONES = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_en;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             frame_err;
  logic             overrun;

  always #5 clk = ~clk;

  nrzi_rx #(.WIDTH(WIDTH), .MAX_ONES(MAX_ONES)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  typedef enum int {EV_WORD, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t         kind;
    logic [WIDTH-1:0] data;
  } ev_t;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             bad_stop;
    int               gap;
    logic             exp_valid;
    logic             exp_err;
    logic [WIDTH-1:0] exp_dout;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic line     = 1'b0;
  logic mon_pv   = 1'b0;
  logic mon_pr   = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(ev_kind_t k, logic [WIDTH-1:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic got(ev_kind_t k, logic [WIDTH-1:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event %0d data 0x%0h, expected no event", k, d);
    end else begin
      e = sb.pop_front();
      check("sb_kind", k, e.kind);
      if (k == EV_WORD) check("sb_data", d, e.data);
    end
  endtask

  // A new word is visible when valid is set and the previous cycle either had no word or handed it off.
  always @(negedge clk) begin
    if (dout_valid && (!mon_pv || mon_pr)) got(EV_WORD, dout);
    if (frame_err) got(EV_FERR, '0);
    if (overrun) got(EV_OVR, '0);
    mon_pv = dout_valid;
    mon_pr = dout_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b, int gap);
    for (int i = 0; i < gap; i++) begin
      din_en = 1'b0;
      din    = 1'($urandom);
      tick();
    end
    din_en = 1'b1;
    if (b) line = ~line;
    din = line;
    tick();
    din_en = 1'b0;
    din    = line;
  endtask

  task automatic send_frame(logic [WIDTH-1:0] w, logic bad_stop, int gap, logic ready_on_stop);
`ifdef BIT_UNSTUFF_EN
    int ones = 0;
`endif
    send_bit(1'b1, gap);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], gap);
`ifdef BIT_UNSTUFF_EN
      ones = w[i] ? ones + 1 : 0;
      if (ones == MAX_ONES && i < WIDTH - 1) begin
        send_bit(1'b0, gap);
        ones = 0;
      end
`endif
    end
    if (ready_on_stop) dout_ready = 1'b1;
    send_bit(bad_stop, gap);
    if (ready_on_stop) dout_ready = 1'b0;
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;

    vecs[0] = '{8'hA5, 1'b0, 0, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'h3C, 1'b0, 0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'hA5, 1'b0, 2, 1'b1, 1'b0, 8'hA5};
    vecs[6] = '{8'h81, 1'b1, 2, 1'b0, 1'b1, 8'hA5};

    rst        = 1'b1;
    din        = 1'b0;
    din_en     = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst  = 1'b0;
    line = 1'b0;
    tick();

    // Table: first entry is the 1,0,0,1,1,1,0,0,1,1 line sequence; gap=2 entries strobe 1-of-3 cycles.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].bad_stop) expect_ev(EV_FERR, '0);
      else expect_ev(EV_WORD, vecs[i].word);
      send_frame(vecs[i].word, vecs[i].bad_stop, vecs[i].gap, 1'b0);
      check($sformatf("vec%0d_valid", i), dout_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_err", i), frame_err, vecs[i].exp_err);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      consume();
      check($sformatf("vec%0d_err_clear", i), frame_err, 0);
      check($sformatf("vec%0d_valid_clear", i), dout_valid, 0);
    end

    // Second completion while the first word is still held is dropped.
    expect_ev(EV_WORD, 8'hA5);
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    expect_ev(EV_OVR, '0);
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    check("ovr_pulse", overrun, 1);
    check("ovr_dout_held", dout, 8'hA5);
    check("ovr_valid", dout_valid, 1);
    tick();
    check("ovr_one_cycle", overrun, 0);
    check("ovr_dout_held2", dout, 8'hA5);
    consume();

    // Ready in the completion cycle lets the second word replace the first.
    expect_ev(EV_WORD, 8'hA5);
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    expect_ev(EV_WORD, 8'h3C);
    send_frame(8'h3C, 1'b0, 0, 1'b1);
    check("rdy_dout", dout, 8'h3C);
    check("rdy_valid", dout_valid, 1);
    check("rdy_no_ovr", overrun, 0);
    consume();
    check("rdy_valid_clear", dout_valid, 0);

    // Reset after four data bits, with a strobed toggle in the reset cycle.
    w = 8'h5A;
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(w[i], 0);
    rst    = 1'b1;
    din_en = 1'b1;
    din    = ~line;
    tick();
    rst    = 1'b0;
    din_en = 1'b0;
    line   = 1'b0;
    din    = 1'b0;
    check("midrst_dout", dout, 0);
    check("midrst_valid", dout_valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    tick();
    check("midrst_no_err_pulse", frame_err, 0);
    expect_ev(EV_WORD, 8'h5A);
    send_frame(8'h5A, 1'b0, 0, 1'b0);
    check("post_rst_dout", dout, 8'h5A);
    check("post_rst_valid", dout_valid, 1);
    consume();

`ifdef BIT_UNSTUFF_EN
    // Six ones followed by a stuff position carrying 1.
    expect_ev(EV_FERR, '0);
    send_bit(1'b1, 0);
    for (int i = 0; i < MAX_ONES; i++) send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check("stuff1_err", frame_err, 1);
    check("stuff1_valid", dout_valid, 0);
    tick();
    check("stuff1_err_clear", frame_err, 0);
    expect_ev(EV_WORD, 8'hDE);
    send_frame(8'hDE, 1'b0, 0, 1'b0);
    check("stuff_recover_dout", dout, 8'hDE);
    consume();
`else
    // Seven ones in a row carry no stuff bit in this build.
    expect_ev(EV_WORD, 8'h7F);
    send_frame(8'h7F, 1'b0, 0, 1'b0);
    check("nostuff_dout", dout, 8'h7F);
    check("nostuff_err", frame_err, 0);
    consume();
`endif

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
